// File: rtl/cache_req_tag_if.sv
// CPU request / FSM strobe bundle for cache_req_tag.
// Optional counter signals are present only when HIT_MISS_CNT_EN is defined.
interface cache_req_tag_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned INDEX_W = 3
);
    logic               cs;
    logic               wr_rd_cpu;
    logic [ADDR_W-1:0]  addr_cpu;
    logic               rdy;
    logic               set_valid;
    logic               set_dirty;
    logic               cs_sampled_dly;
    logic               wr_rd_cpu_q;
    logic               hit;
    logic               dirty_line;
    logic [INDEX_W-1:0] sram_index;
    logic [ADDR_W-1:0]  fill_addr;
    logic [ADDR_W-1:0]  victim_addr;
`ifdef HIT_MISS_CNT_EN
    logic [15:0]        hit_cnt;
    logic [15:0]        miss_cnt;
`endif

    // CPU / cache_fsm side
    modport master (
`ifdef HIT_MISS_CNT_EN
        input  hit_cnt, miss_cnt,
`endif
        output cs, wr_rd_cpu, addr_cpu, rdy, set_valid, set_dirty,
        input  cs_sampled_dly, wr_rd_cpu_q, hit, dirty_line,
        input  sram_index, fill_addr, victim_addr
    );

    // tag front end side
    modport slave (
`ifdef HIT_MISS_CNT_EN
        output hit_cnt, miss_cnt,
`endif
        input  cs, wr_rd_cpu, addr_cpu, rdy, set_valid, set_dirty,
        output cs_sampled_dly, wr_rd_cpu_q, hit, dirty_line,
        output sram_index, fill_addr, victim_addr
    );
endinterface

// File: rtl/cache_req_tag.sv
// CPU-side request sampler and direct-mapped tag/valid/dirty store feeding cache_fsm.
// Define HIT_MISS_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_req_tag #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned INDEX_W     = 3,
    parameter int unsigned BLOCKSIZE_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    cache_req_tag_if.slave  bus
);
    localparam int unsigned TAG_W = ADDR_W - INDEX_W - BLOCKSIZE_W;
    localparam int unsigned LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT_BUSY,
        S_WAIT_RDY
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_idx;
    logic               w_bypass;
    logic               w_hit;
    logic               w_unused_offset;

    logic [TAG_W-1:0]   r_tag_q;
    logic [INDEX_W-1:0] r_idx_q;
    logic               r_wr_rd_q;
    logic               r_hit;
    logic               r_cs_dly;

    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [TAG_W-1:0]   r_tag_arr [LINES];

    assign w_tag           = bus.addr_cpu[ADDR_W-1 -: TAG_W];
    assign w_idx           = bus.addr_cpu[BLOCKSIZE_W +: INDEX_W];
    assign w_unused_offset = ^bus.addr_cpu[BLOCKSIZE_W-1:0];

    // A same-cycle install at the looked-up index is visible to the lookup
    assign w_bypass = bus.set_valid && (r_idx_q == w_idx);
    assign w_hit    = w_bypass ? (r_tag_q == w_tag)
                               : (r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cs && bus.rdy) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP:    w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!bus.rdy) w_state_nxt = S_WAIT_RDY;
            S_WAIT_RDY:  if (bus.rdy)  w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch and tag store update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_q   <= '0;
            r_idx_q   <= '0;
            r_wr_rd_q <= 1'b0;
            r_hit     <= 1'b0;
            r_cs_dly  <= 1'b0;
            r_valid   <= '0;
            r_dirty   <= '0;
            for (int i = 0; i < int'(LINES); i++) begin
                r_tag_arr[i] <= '0;
            end
        end else begin
            r_cs_dly <= w_accept;
            if (bus.set_valid) begin
                r_valid[r_idx_q]   <= 1'b1;
                r_tag_arr[r_idx_q] <= r_tag_q;
                r_dirty[r_idx_q]   <= bus.set_dirty;
            end else if (bus.set_dirty && r_valid[r_idx_q]) begin
                r_dirty[r_idx_q]   <= 1'b1;
            end
            if (w_accept) begin
                r_tag_q   <= w_tag;
                r_idx_q   <= w_idx;
                r_wr_rd_q <= bus.wr_rd_cpu;
                r_hit     <= w_hit;
            end
        end
    end

    assign bus.cs_sampled_dly = r_cs_dly;
    assign bus.wr_rd_cpu_q    = r_wr_rd_q;
    assign bus.hit            = r_hit;
    assign bus.dirty_line     = r_valid[r_idx_q] & r_dirty[r_idx_q];
    assign bus.sram_index     = r_idx_q;
    assign bus.fill_addr      = {r_tag_q, r_idx_q, BLOCKSIZE_W'(0)};
    assign bus.victim_addr    = {r_tag_arr[r_idx_q], r_idx_q, BLOCKSIZE_W'(0)};

`ifdef HIT_MISS_CNT_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Saturating lookup statistics, counted once per request in LOOKUP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (r_hit) begin
                if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
                if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign bus.hit_cnt  = r_hit_cnt;
    assign bus.miss_cnt = r_miss_cnt;
`endif

endmodule
